// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// mul_div_unit : HI/LO multiply / multiply-accumulate / restoring-divide unit
// Revision     : 1.0
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] out
);

  localparam int CNT_W = 7;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MFHI  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [WIDTH-1:0]     opa, opb;
  logic                 mul_signed, mul_acc, mul_sub;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     rem, quo, dvs;
  logic                 q_neg, r_neg;

  // Multiply datapath: operands widened to 2*WIDTH so the truncated product
  // is correct modulo 2^(2*WIDTH) for both signed and unsigned forms.
  logic [2*WIDTH-1:0]   ext_a, ext_b, prod, mul_result;
  assign ext_a = mul_signed ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
  assign ext_b = mul_signed ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
  assign prod  = ext_a * ext_b;
  assign mul_result = !mul_acc ? prod : (mul_sub ? acc - prod : acc + prod);

  // One restoring-divide step; remainder stays below divisor so diff fits WIDTH.
  logic [WIDTH:0]       partial;
  logic                 fits;
  logic [WIDTH-1:0]     diff;
  assign partial = {rem, quo[WIDTH-1]};
  assign fits    = partial >= {1'b0, dvs};
  assign diff    = partial[WIDTH-1:0] - dvs;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  assign a_neg = (op == OP_DIV) && a[WIDTH-1];
  assign b_neg = (op == OP_DIV) && b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign busy = (state != S_IDLE);
  assign out  = (op == OP_MFHI) ? hi : (op == OP_MFLO) ? lo : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      hi         <= '0;
      lo         <= '0;
      opa        <= '0;
      opb        <= '0;
      mul_signed <= 1'b0;
      mul_acc    <= 1'b0;
      mul_sub    <= 1'b0;
      acc        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                opa        <= a;
                opb        <= b;
                mul_signed <= (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
                mul_acc    <= op[3];
                mul_sub    <= op[3] & op[1];
                acc        <= {hi, lo};
                count      <= CNT_W'(MUL_LAT - 1);
                state      <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                opa   <= a;
                quo   <= a_mag;
                dvs   <= b_mag;
                rem   <= '0;
                q_neg <= a_neg ^ b_neg;
                r_neg <= a_neg;
                count <= CNT_W'(WIDTH - 1);
                state <= S_DIV;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (count == '0) begin
            {hi, lo} <= mul_result;
            state    <= S_IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        S_DIV: begin
          rem <= fits ? diff : partial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], fits};
          if (count == '0) state <= S_FIX;
          else             count <= count - 1'b1;
        end
        S_FIX: begin
          // Divide by zero bypasses sign correction and reports all-ones / dividend.
          if (dvs == '0) begin
            lo <= '1;
            hi <= opa;
          end else begin
            lo <= q_neg ? -quo : quo;
            hi <= r_neg ? -rem : rem;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// Testbench for mul_div_unit: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results (WIDTH=32 and WIDTH=16 instances).
module tb_mul_div_unit;

  localparam int W   = 32;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          reset, start, flush;
  logic [3:0]    op;
  logic [W-1:0]  a, b;
  logic          busy;
  logic [W-1:0]  hi, lo, out;

  logic          start16, flush16;
  logic [3:0]    op16;
  logic [15:0]   a16, b16;
  logic          busy16;
  logic [15:0]   hi16, lo16, out16;

  mul_div_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .hi(hi), .lo(lo), .out(out)
  );

  mul_div_unit #(.WIDTH(16), .MUL_LAT(1)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
    .flush(flush16), .busy(busy16), .hi(hi16), .lo(lo16), .out(out16)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_mul(input logic [3:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input logic [63:0] hl);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 4'd0 || o == 4'd8 || o == 4'd10) p = 64'(sx * sy);
    else                                      p = {32'h0, x} * {32'h0, y};
    if (o == 4'd8 || o == 4'd9)        return hl + p;
    else if (o == 4'd10 || o == 4'd11) return hl - p;
    else                               return p;
  endfunction

  function automatic logic [63:0] model_div(input logic [3:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    int sx, sy, q, r;
    if (y == 32'h0) return {x, 32'hFFFF_FFFF};
    if (o == 4'd2) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sx = $signed(x);
      sy = $signed(y);
      q = sx / sy;
      r = sx % sy;
      return {r, q};
    end
    return {x % y, x / y};
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else if (flush) begin
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) {m_hi, m_lo} <= m_pend;
    end else if (start) begin
      case (op)
        4'd0, 4'd1, 4'd8, 4'd9, 4'd10, 4'd11: begin
          m_pend <= model_mul(op, a, b, {m_hi, m_lo});
          m_left <= LAT;
        end
        4'd2, 4'd3: begin
          m_pend <= model_div(op, a, b);
          m_left <= W + 1;
        end
        4'd6: m_hi <= a;
        4'd7: m_lo <= a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model_busy", 64'(busy), 64'(m_left > 0));
      check("model_hi", 64'(hi), 64'(m_hi));
      check("model_lo", 64'(lo), 64'(m_lo));
      check("model_out", 64'(out), 64'((op == 4'd4) ? m_hi : (op == 4'd5) ? m_lo : 32'h0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #2;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #2;
    start = 1'b0; op = 4'd4; a = '0; b = '0;
  endtask

  task automatic wait_idle(output int cyc);
    bit done;
    done = 1'b0;
    cyc  = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (busy) cyc++;
      else      done = 1'b1;
    end
    check("idle_timeout", 64'(done), 64'(1));
  endtask

  int cyc;

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 4'd4; a = '0; b = '0;
    start16 = 1'b0; flush16 = 1'b0; op16 = 4'd4; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));

    issue(4'd0, 32'hFFFF_FFFF, 32'd2); wait_idle(cyc);
    check("mult_busy_cycles", 64'(cyc), 64'(5));
    check("mult_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_lo", 64'(lo), 64'h0000_0000_FFFF_FFFE);

    issue(4'd1, 32'hFFFF_FFFF, 32'd2); wait_idle(cyc);
    check("multu_hi", 64'(hi), 64'(1));
    check("multu_lo", 64'(lo), 64'h0000_0000_FFFF_FFFE);

    issue(4'd2, 32'hFFFF_FFF9, 32'd2); wait_idle(cyc);
    check("div_busy_cycles", 64'(cyc), 64'(33));
    check("div_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    check("div_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);

    issue(4'd3, 32'd7, 32'd0); wait_idle(cyc);
    check("divu_zero_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    check("divu_zero_hi", 64'(hi), 64'(7));

    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(cyc);
    check("div_ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
    check("div_ovf_hi", 64'(hi), 64'(0));

    issue(4'd2, 32'd100, 32'hFFFF_FFF9); wait_idle(cyc);
    check("div_negb_lo", 64'(lo), 64'h0000_0000_FFFF_FFF2);
    check("div_negb_hi", 64'(hi), 64'(2));

    issue(4'd6, 32'd0, 32'd0); wait_idle(cyc);
    check("mthi_busy", 64'(cyc), 64'(0));
    issue(4'd7, 32'd10, 32'd0); wait_idle(cyc);
    check("mtlo_lo", 64'(lo), 64'(10));
    issue(4'd8, 32'd3, 32'd4); wait_idle(cyc);
    check("madd_hi", 64'(hi), 64'(0));
    check("madd_lo", 64'(lo), 64'(22));
    issue(4'd11, 32'd23, 32'd1); wait_idle(cyc);
    check("msubu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("msubu_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);

    issue(4'd12, 32'd5, 32'd5); wait_idle(cyc);
    check("reserved_busy", 64'(cyc), 64'(0));
    check("reserved_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mfhi_out", 64'(out), 64'h0000_0000_FFFF_FFFF);

    // start during busy is ignored
    issue(4'd2, 32'd100, 32'd7);
    @(posedge clk); #2;
    @(posedge clk); #2;
    start = 1'b1; op = 4'd0; a = 32'd9; b = 32'd9;
    @(posedge clk); #2;
    start = 1'b0; op = 4'd4; a = '0; b = '0;
    wait_idle(cyc);
    check("ignore_remaining_busy", 64'(cyc), 64'(30));
    check("ignore_lo", 64'(lo), 64'(14));
    check("ignore_hi", 64'(hi), 64'(2));

    // flush mid-divide, with a simultaneous start that must be dropped
    issue(4'd2, 32'd50, 32'd3);
    repeat (9) @(posedge clk);
    #2 flush = 1'b1; start = 1'b1; op = 4'd0; a = 32'd3; b = 32'd3;
    @(posedge clk); #2;
    flush = 1'b0; start = 1'b0; op = 4'd5; a = '0; b = '0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_hi", 64'(hi), 64'(2));
    check("flush_lo", 64'(lo), 64'(14));
    @(negedge clk);
    check("flush_start_dropped", 64'(busy), 64'(0));

    // reset mid-multiply
    issue(4'd0, 32'd5, 32'd6);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0; op = 4'd4;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_hi", 64'(hi), 64'(0));
    check("rst_mid_lo", 64'(lo), 64'(0));
    check("rst_mid_out", 64'(out), 64'(0));

    // 16-bit, single-cycle multiply instance
    @(posedge clk); #2;
    start16 = 1'b1; op16 = 4'd0; a16 = 16'h8000; b16 = 16'h8000;
    @(posedge clk); #2;
    start16 = 1'b0; op16 = 4'd4; a16 = '0; b16 = '0;
    begin
      int c16;
      bit d16;
      c16 = 0;
      d16 = 1'b0;
      for (int k = 0; k < 50 && !d16; k++) begin
        @(negedge clk);
        if (busy16) c16++;
        else        d16 = 1'b1;
      end
      check("w16_idle_timeout", 64'(d16), 64'(1));
      check("w16_busy_cycles", 64'(c16), 64'(1));
    end
    check("w16_hi", 64'(hi16), 64'h4000);
    check("w16_lo", 64'(lo16), 64'h0000);
    check("w16_out_hi", 64'(out16), 64'h4000);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width; legal values 8..64, even.
REQ-002 Parameter MUL_LAT, default 5: multiply busy cycles; legal 1..16.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  issue strobe; sampled only on a posedge where busy==0 and flush==0.
REQ-006 op  input  4  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO, 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU, 12-15 reserved.
REQ-007 a  input  WIDTH  operand 1 (dividend / multiplicand / MTHI-MTLO data).
REQ-008 b  input  WIDTH  operand 2 (divisor / multiplier).
REQ-009 flush  input  1  abort in-flight operation (exception/interrupt kill).
REQ-010 busy  output  1  high while a multi-cycle operation is in flight.
REQ-011 hi  output  WIDTH  architectural HI register.
REQ-012 lo  output  WIDTH  architectural LO register.
REQ-013 out  output  WIDTH  read port: hi when op==4, lo when op==5, otherwise 0; combinational, independent of start/busy.

Function
REQ-014 The block SHALL implement states IDLE, MUL, DIV, FIX; busy SHALL be 1 exactly in MUL, DIV, FIX.
REQ-015 In IDLE, start with op in {0,1,8..11} SHALL latch operands, go to MUL with counter=MUL_LAT-1, busy rising the next cycle.
REQ-016 MUL SHALL hold for exactly MUL_LAT cycles, then write HI/LO and return to IDLE on the same edge busy falls.
REQ-017 MULT/MULTU SHALL set {hi,lo} = signed/unsigned 2*WIDTH-bit product of a and b.
REQ-018 MADD(U)/MSUB(U) SHALL set {hi,lo} = {hi,lo} +/- product, using {hi,lo} values at start time, modulo 2^(2*WIDTH), signedness per op.
REQ-019 In IDLE, start with op in {2,3} SHALL enter DIV; the divider SHALL be iterative restoring, one quotient bit per cycle, WIDTH cycles in DIV, then one cycle in FIX (sign correction), busy high WIDTH+1 cycles total.
REQ-020 DIV/DIVU SHALL set lo=quotient truncated toward zero, hi=remainder with sign of dividend (DIV) or unsigned (DIVU).
REQ-021 Divide by zero SHALL complete with normal latency and set lo=all ones, hi=a.
REQ-022 DIV with a=most-negative and b=-1 SHALL set lo=most-negative value, hi=0.
REQ-023 MTHI/MTLO with start in IDLE SHALL write a into hi/lo at that edge, single cycle, busy stays 0.
REQ-024 MFHI/MFLO and reserved ops SHALL never change state or assert busy.
REQ-025 start while busy==1 SHALL be ignored: no state, operand, or HI/LO change.
REQ-026 hi/lo SHALL change only at operation completion or MTHI/MTLO; intermediate values SHALL stay in internal registers.
REQ-027 flush==1 in any state SHALL return to IDLE at that edge with hi/lo unchanged and busy=0 next cycle; flush and start on the same edge SHALL ignore start.
REQ-028 Back-to-back: start accepted on the edge after busy falls SHALL see the just-written hi/lo (relevant to MADD/MSUB).

Reset
REQ-029 reset==1 at a posedge SHALL force IDLE, busy=0, hi=0, lo=0, counter and internal registers 0, taking priority over start and flush, including mid-operation.

Verification
REQ-030 WIDTH=32, MUL_LAT=5: MULT a=0xFFFFFFFF b=2 -> busy 5 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same -> hi=1, lo=0xFFFFFFFE.
REQ-031 DIV a=-7 b=2 -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-032 MTHI 0, MTLO 10, then MADD a=3 b=4 -> hi=0, lo=22; then MSUBU a=23 b=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.
REQ-033 DIV started, start MULT at cycle 3 of busy -> ignored, final result is the division's; flush at cycle 10 of a second DIV -> busy=0 next cycle, hi/lo keep prior values.
REQ-034 reset asserted mid-MUL -> next cycle busy=0, hi=0, lo=0, out(op=4)=0; WIDTH=16, MUL_LAT=1 instance: MULT 0x8000*0x8000 -> busy 1 cycle, hi=0x4000, lo=0.
